fms_i2s_output: RTL and testbench

Audio output stage fed by the `fmicrosynth` core. It owns the sample-rate timebase. Once per frame it latches the core's `sample_l`/`sample_r` and pulses `trigger` so the core computes the next sample pair. It then serialises the latched pair to an external DAC in Philips I2S format, with left channel on `lrclk` low and MSB one `bclk` after the `lrclk` edge. It detects and flags underruns, where the core is still running at frame start.

---
 rtl/fms_i2s_output_pkg.sv | 32 +++
 rtl/fms_bclk_gen.sv | 82 ++++++++
 rtl/fms_i2s_output.sv | 156 +++++++++++++++
 tb/tb_fms_i2s_output.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fms_i2s_output_pkg.sv
// ---------------------------------------------------------------------------
// fms_i2s_output_pkg
//
// Shared frame-layout constants for the fmicrosynth audio output path, plus
// the small helpers used by the I2S output stage and its bit-clock generator.
// Testbenches and the top level import this so that slot width, divider and
// channel polarity cannot drift apart.
// ---------------------------------------------------------------------------
package fms_i2s_output_pkg;

    // Default frame layout: 32 bclk per slot, 16 clk per bclk half-period.
    localparam int DEFAULT_DATA_BITS = 16;
    localparam int DEFAULT_SLOT_BITS = 32;
    localparam int DEFAULT_BCLK_DIV  = 16;

    // Philips I2S: left channel is transmitted while lrclk is low.
    localparam logic LRCLK_LEFT = 1'b0;

    // What the output stage does with its sample latches on a frame event.
    typedef enum logic [1:0] {
        FRAME_IDLE,    // not a frame event
        FRAME_NEW,     // core finished: latch the new pair and trigger it
        FRAME_REPEAT,  // core still busy: resend the last pair, flag underrun
        FRAME_SILENT   // core busy on the very first frame: send silence
    } frame_act_e;

    // Counter width for a counter spanning 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fms_bclk_gen.sv
// ---------------------------------------------------------------------------
// fms_bclk_gen
//
// I2S timebase. Divides clk down to bclk and tracks the bit position inside
// the stereo frame. Produces single-cycle strobes on the clk cycle whose edge
// carries each bclk falling transition (fall) and on the one that starts a
// new frame (frame), so the parent can update its own registers on exactly
// the same edge as bclk/lrclk.
//
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   bclk         registered I2S bit clock
//   lrclk        registered I2S word select (LRCLK_LEFT = left slot)
//   fall         high in the cycle whose edge takes bclk 1 -> 0
//   frame        high in the fall cycle that wraps the bit counter to 0
// ---------------------------------------------------------------------------
module fms_bclk_gen
    import fms_i2s_output_pkg::*;
#(
    parameter int SLOT_BITS = DEFAULT_SLOT_BITS,
    parameter int BCLK_DIV  = DEFAULT_BCLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic bclk,
    output logic lrclk,
    output logic fall,
    output logic frame
);

    localparam int DIV_W = cnt_width(BCLK_DIV);
    localparam int BIT_W = cnt_width(2 * SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_START = BIT_W'(SLOT_BITS);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic             wrap;

    // NOTE: every signal driven here gets a default before any condition;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        wrap      = (div_cnt_q == DIV_LAST);
        fall      = wrap && bclk_q;
        frame     = fall && (bit_cnt_q == BIT_LAST);

        div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
        bclk_d    = wrap ? ~bclk_q : bclk_q;
        bit_cnt_d = bit_cnt_q;
        lrclk_d   = lrclk_q;

        if (fall) begin
            bit_cnt_d = frame ? '0 : bit_cnt_q + 1'b1;
            // Word select follows the bit position the frame is moving into.
            lrclk_d   = (bit_cnt_d >= SLOT_START) ? ~LRCLK_LEFT : LRCLK_LEFT;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            bit_cnt_q <= BIT_LAST;     // first fall event becomes a frame event
            bclk_q    <= 1'b0;
            lrclk_q   <= ~LRCLK_LEFT;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
        end
    end

    assign bclk  = bclk_q;
    assign lrclk = lrclk_q;

endmodule

// File: rtl/fms_i2s_output.sv
// ---------------------------------------------------------------------------
// fms_i2s_output
//
// Audio output stage for the fmicrosynth core. Owns the sample-rate
// timebase: once per frame it latches the core's stereo pair, pulses trigger
// so the core starts on the next pair, and serialises the latched pair to
// the DAC in Philips I2S format (left on lrclk low, MSB one bclk after the
// lrclk edge). If the core is still running at a frame boundary the previous
// pair is resent and the sticky underrun flag is raised.
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   sample_l/_r    signed samples from the core, sampled on frame events only
//   running        core busy flag
//   underrun_clr   one-cycle pulse clearing underrun (a same-cycle set wins)
//   trigger        one-cycle pulse: core may start the next sample
//   bclk, lrclk    registered I2S bit clock and word select
//   sdata          registered I2S serial data
//   underrun       sticky underrun flag
// ---------------------------------------------------------------------------
module fms_i2s_output
    import fms_i2s_output_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int SLOT_BITS = DEFAULT_SLOT_BITS,
    parameter int BCLK_DIV  = DEFAULT_BCLK_DIV
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] sample_l,
    input  logic [DATA_BITS-1:0] sample_r,
    input  logic                 running,
    input  logic                 underrun_clr,
    output logic                 trigger,
    output logic                 bclk,
    output logic                 lrclk,
    output logic                 sdata,
    output logic                 underrun
);

    localparam int FRAME_W = 2 * SLOT_BITS;

    logic                 fall;
    logic                 frame;
    frame_act_e           act;

    logic [DATA_BITS-1:0] left_q, left_d;
    logic [DATA_BITS-1:0] right_q, right_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic                 sdata_q, sdata_d;
    logic                 trigger_q, trigger_d;
    logic                 underrun_q, underrun_d;
    logic                 first_frame_q, first_frame_d;

    fms_bclk_gen #(
        .SLOT_BITS (SLOT_BITS),
        .BCLK_DIV  (BCLK_DIV)
    ) u_bclk_gen (
        .clk   (clk),
        .reset (reset),
        .bclk  (bclk),
        .lrclk (lrclk),
        .fall  (fall),
        .frame (frame)
    );

    // Frame word: {L, zero pad, R, zero pad}, MSB transmitted first.
    function automatic logic [FRAME_W-1:0] frame_word(
        input logic [DATA_BITS-1:0] l,
        input logic [DATA_BITS-1:0] r
    );
        logic [FRAME_W-1:0] w;
        w                            = '0;
        w[FRAME_W-1   -: DATA_BITS]  = l;
        w[SLOT_BITS-1 -: DATA_BITS]  = r;
        return w;
    endfunction

    always_comb begin
        act = FRAME_IDLE;
        if (frame) begin
            if (!running)          act = FRAME_NEW;
            else if (first_frame_q) act = FRAME_SILENT;
            else                   act = FRAME_REPEAT;
        end

        left_d        = left_q;
        right_d       = right_q;
        shreg_d       = shreg_q;
        sdata_d       = sdata_q;
        trigger_d     = 1'b0;
        first_frame_d = first_frame_q;

        // The shift register's MSB is always the next bit to send. On the
        // frame event it holds the old word's bit 0 (the final pad bit, or
        // the right LSB when there is no padding), which goes out during
        // the first bclk of the new frame as Philips I2S requires.
        if (fall) begin
            sdata_d = shreg_q[FRAME_W-1];
            shreg_d = shreg_q << 1;
        end

        case (act)
            FRAME_NEW: begin
                left_d        = sample_l;
                right_d       = sample_r;
                shreg_d       = frame_word(sample_l, sample_r);
                trigger_d     = 1'b1;
                first_frame_d = 1'b0;
            end
            FRAME_REPEAT: begin
                shreg_d       = frame_word(left_q, right_q);
                first_frame_d = 1'b0;
            end
            FRAME_SILENT: begin
                left_d        = '0;
                right_d       = '0;
                shreg_d       = '0;
                first_frame_d = 1'b0;
            end
            default: ;
        endcase

        // A new underrun outranks a clear arriving in the same cycle.
        if (act == FRAME_REPEAT) underrun_d = 1'b1;
        else if (underrun_clr)   underrun_d = 1'b0;
        else                     underrun_d = underrun_q;
    end

    // NOTE: the sample latches and shift register are reset along with the
    // control flops because their contents reach sdata on the first frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            left_q        <= '0;
            right_q       <= '0;
            shreg_q       <= '0;
            sdata_q       <= 1'b0;
            trigger_q     <= 1'b0;
            underrun_q    <= 1'b0;
            first_frame_q <= 1'b1;
        end else begin
            left_q        <= left_d;
            right_q       <= right_d;
            shreg_q       <= shreg_d;
            sdata_q       <= sdata_d;
            trigger_q     <= trigger_d;
            underrun_q    <= underrun_d;
            first_frame_q <= first_frame_d;
        end
    end

    assign trigger  = trigger_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_fms_i2s_output.sv
// ---------------------------------------------------------------------------
// tb_fms_i2s_output
//
// Bench for fms_i2s_output with BCLK_DIV=2, SLOT_BITS=16, DATA_BITS=16
// (128 clk per frame). A cycle-count model derives every output from the
// number of clk edges since reset; a negedge process compares it with the
// DUT every cycle. Directed sequences add literal expectations for latency,
// frame period, serial content, underrun handling and reset behaviour.
// ---------------------------------------------------------------------------
module tb_fms_i2s_output;

    localparam int DB = 16;
    localparam int SB = 16;
    localparam int BD = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [DB-1:0] sample_l;
    logic [DB-1:0] sample_r;
    logic          running;
    logic          underrun_clr;
    logic          trigger;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          underrun;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fms_i2s_output #(
        .DATA_BITS (DB),
        .SLOT_BITS (SB),
        .BCLK_DIV  (BD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .running      (running),
        .underrun_clr (underrun_clr),
        .trigger      (trigger),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: mk = clk edges since the last reset edge. bclk has period
    // 4 clk, so bclk falls at mk = 4, 8, ...; fall n carries bit b=(n-1)%32.
    // ------------------------------------------------------------------
    int unsigned m_k;
    bit          m_valid = 1'b0;
    bit          m_first;
    bit          m_set;
    logic [15:0] m_l, m_r;
    logic [31:0] m_word;
    logic        m_lrclk, m_sdata, m_trig, m_und;
    int          m_n, m_b;

    always @(posedge clk) begin
        if (reset) begin
            m_k = 0; m_first = 1'b1; m_l = '0; m_r = '0; m_word = '0;
            m_lrclk = 1'b1; m_sdata = 1'b0; m_trig = 1'b0; m_und = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_k++;
            m_trig = 1'b0;
            m_set  = 1'b0;
            if (m_k % 4 == 0) begin
                m_n = int'(m_k / 4);
                m_b = (m_n - 1) % 32;
                m_lrclk = (m_b >= 16);
                if (m_b == 0) begin
                    m_sdata = m_word[0];
                    if (!running) begin
                        m_l = sample_l; m_r = sample_r; m_trig = 1'b1;
                    end else if (!m_first) begin
                        m_set = 1'b1;
                    end else begin
                        m_l = '0; m_r = '0;
                    end
                    m_word  = {m_l, m_r};
                    m_first = 1'b0;
                end else begin
                    m_sdata = m_word[32 - m_b];
                end
            end
            m_und = m_set ? 1'b1 : (underrun_clr ? 1'b0 : m_und);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("bclk",     bclk,     (m_k / 2) % 2);
            check("lrclk",    lrclk,    m_lrclk);
            check("sdata",    sdata,    m_sdata);
            check("trigger",  trigger,  m_trig);
            check("underrun", underrun, m_und);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until trigger is seen, bounded; -1 if it never comes.
    task automatic wait_trigger(output int cnt);
        bit seen;
        seen = 1'b0;
        cnt  = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step();
            cnt++;
            if (trigger) seen = 1'b1;
        end
        if (!seen) cnt = -1;
    endtask

    // Called just after a frame event edge: samples sdata on the next 33
    // bclk rises (rise 0 is the previous word's last bit) over 130 edges.
    task automatic capture(output logic [15:0] l, output logic [15:0] r,
                           output int trig_cnt, output int trig_at,
                           output int low_cnt);
        logic        prev;
        int          rise;
        logic [32:0] bits;
        prev     = bclk;
        rise     = 0;
        bits     = '0;
        trig_cnt = 0;
        trig_at  = -1;
        low_cnt  = (lrclk == 1'b0) ? 1 : 0;
        for (int i = 1; i <= 130; i++) begin
            step();
            if (bclk && !prev) begin
                if (rise <= 32) bits[rise] = sdata;
                rise++;
            end
            prev = bclk;
            if (trigger) begin
                trig_cnt++;
                trig_at = i;
            end
            if (i <= 127 && lrclk == 1'b0) low_cnt++;
        end
        for (int j = 0; j < 16; j++) begin
            l[15-j] = bits[1+j];
            r[15-j] = bits[17+j];
        end
    endtask

    logic [15:0] cap_l, cap_r;
    int          lat, tcnt, tat, lows;

    initial begin
        reset        = 1'b1;
        running      = 1'b0;
        underrun_clr = 1'b0;
        sample_l     = 16'hA5C3;
        sample_r     = 16'h8001;

        // Reset and free-running frames.
        repeat (3) step();
        reset = 1'b0;
        wait_trigger(lat);
        check("first_trigger_latency", lat, 4);
        check("lrclk_low_at_frame", lrclk, 1'b0);
        capture(cap_l, cap_r, tcnt, tat, lows);
        check("serial_left",  cap_l, 16'hA5C3);
        check("serial_right", cap_r, 16'h8001);
        check("triggers_per_frame", tcnt, 1);
        check("trigger_period", tat, 128);
        check("lrclk_low_cycles", lows, 64);

        // Underrun with a clear colliding on the same frame event.
        running  = 1'b1;
        sample_l = 16'h1234;
        sample_r = 16'h5678;
        repeat (125) step();
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check("no_trigger_on_underrun", trigger, 1'b0);
        check("underrun_set_beats_clear", underrun, 1'b1);
        running = 1'b0;
        capture(cap_l, cap_r, tcnt, tat, lows);
        check("repeat_left",  cap_l, 16'hA5C3);
        check("repeat_right", cap_r, 16'h8001);
        check("trigger_resumes", tcnt, 1);

        // Lone clear pulse.
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        step();
        check("underrun_cleared", underrun, 1'b0);

        // Next frame carries the pair latched after the core finished.
        repeat (124) step();
        check("trigger_after_recovery", trigger, 1'b1);
        capture(cap_l, cap_r, tcnt, tat, lows);
        check("new_left",  cap_l, 16'h1234);
        check("new_right", cap_r, 16'h5678);

        // Mid-frame reset while bit_cnt = 20 (bclk high, sdata = R[12] = 1).
        repeat (80) step();
        check("pre_reset_bclk",  bclk,  1'b1);
        check("pre_reset_sdata", sdata, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_bclk",    bclk,    1'b0);
        check("reset_lrclk",   lrclk,   1'b1);
        check("reset_sdata",   sdata,   1'b0);
        check("reset_trigger", trigger, 1'b0);
        wait_trigger(lat);
        check("restart_trigger_latency", lat, 4);

        // First-frame suppression with the core busy across reset.
        reset   = 1'b1;
        running = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (4) step();
        check("first_frame_no_trigger",  trigger,  1'b0);
        check("first_frame_no_underrun", underrun, 1'b0);
        check("first_frame_lrclk",       lrclk,    1'b0);
        capture(cap_l, cap_r, tcnt, tat, lows);
        check("silent_left",  cap_l, 16'h0000);
        check("silent_right", cap_r, 16'h0000);
        check("silent_no_trigger", tcnt, 0);
        check("second_busy_frame_underrun", underrun, 1'b1);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
